// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: parity codes, FSM states, baud helper.
package uart_tx_buffered_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic int clocks_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; write ignored when full, read ignored when empty.
// Read data is the head entry, valid whenever empty is low.
module uart_tx_buffered_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with transmit FIFO; frames go out back-to-back while words are queued.
// Word accepted into an empty FIFO while idle starts its start bit one clock later; tx_ready = FIFO not full.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = clocks_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS);

  tx_state_t                 state;
  logic [CW-1:0]             baud_cnt;
  logic [BW-1:0]             bit_idx;
  logic [PAYLOAD_BITS-1:0]   shift_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      stop2_q;
  logic                      stop_sec_q;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [PAYLOAD_BITS-1:0]   fifo_dat;
  logic                      bit_end;
  logic                      last_stop;
  logic                      lat_par_en;
  logic                      lat_par_bit;

  uart_tx_buffered_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (tx_valid),
    .push_dat (tx_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign tx_ready  = !fifo_full;
  assign bit_end   = (baud_cnt == CW'(CPB - 1));
  assign last_stop = (state == ST_STOP) && bit_end && (!stop2_q || stop_sec_q);
  assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || last_stop);

  // Frame options are sampled only at the pop so mid-frame changes never corrupt a frame.
  always_comb begin
    lat_par_en  = 1'b0;
    lat_par_bit = 1'b0;
    case (parity_mode)
      PARITY_EVEN: begin lat_par_en = 1'b1; lat_par_bit = ^fifo_dat;  end
      PARITY_ODD:  begin lat_par_en = 1'b1; lat_par_bit = ~^fifo_dat; end
      PARITY_NONE: lat_par_en = 1'b0;
      default:     lat_par_en = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      stop_sec_q   <= 1'b0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else begin
      if (state == ST_IDLE || bit_end) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;

      case (state)
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            uart_txd <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BW'(PAYLOAD_BITS - 1)) begin
              bit_idx <= '0;
              if (par_en_q) begin
                state    <= ST_PARITY;
                uart_txd <= par_bit_q;
              end else begin
                state    <= ST_STOP;
                uart_txd <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              uart_txd <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            uart_txd <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_sec_q) begin
              stop_sec_q <= 1'b1;
            end else if (fifo_empty) begin
              state        <= ST_IDLE;
              uart_tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
        end
      endcase

      // A pop (from idle or at the end of the last stop bit) starts the next frame immediately.
      if (fifo_pop) begin
        state        <= ST_START;
        uart_txd     <= 1'b0;
        uart_tx_busy <= 1'b1;
        shift_q      <= fifo_dat;
        par_en_q     <= lat_par_en;
        par_bit_q    <= lat_par_bit;
        stop2_q      <= stop2;
        stop_sec_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at 10 clocks per bit; a line monitor decodes every frame.
module tb_uart_tx_buffered;

  logic       CLK = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic [4:0] fifo_level;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       s2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rst_cnt = 0;

  uart_tx_buffered #(
    .CLK_HZ       (1000000),
    .BIT_RATE     (100000),
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (16)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .fifo_level   (fifo_level)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge reset) rst_cnt = rst_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decodes one frame starting at the first negedge of its start bit.
  task automatic rx_frame();
    exp_t       e;
    logic [7:0] d;
    int         my_rst;
    e      = sb.pop_front();
    my_rst = rst_cnt;
    d      = '0;
    repeat (4) @(negedge CLK);
    if (rst_cnt != my_rst) return;
    check("start_bit", uart_txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge CLK);
      d[i] = uart_txd;
    end
    if (rst_cnt != my_rst) return;
    check("data", d, e.data);
    if (e.mode == 2'b01 || e.mode == 2'b10) begin
      repeat (10) @(negedge CLK);
      if (rst_cnt != my_rst) return;
      check("parity", uart_txd, (e.mode == 2'b01) ? ^e.data : ~^e.data);
    end
    repeat (10) @(negedge CLK);
    if (rst_cnt != my_rst) return;
    check("stop_bit", uart_txd, 1'b1);
    if (e.s2) begin
      repeat (10) @(negedge CLK);
      if (rst_cnt != my_rst) return;
      check("stop_bit2", uart_txd, 1'b1);
    end
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (reset === 1'b1 && uart_txd === 1'b0) begin
        if (sb.size() == 0) check("spurious_start", uart_txd, 1'b1);
        else rx_frame();
      end
    end
  end

  // Leaves tx_valid high; caller decides when to drop it.
  task automatic push(input logic [7:0] d);
    exp_t e;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int t = 0; t < 5000 && !tx_ready; t++) @(negedge CLK);
    if (!tx_ready) check("ready_timeout", tx_ready, 1'b1);
    @(posedge CLK);
    e.data = d;
    e.mode = parity_mode;
    e.s2   = stop2;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic measure_busy(input int start, output int len);
    len = start;
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      if (uart_tx_busy) len++;
      else if (len > 0) break;
    end
  endtask

  task automatic single(input logic [7:0] d, input logic [1:0] m, input logic s2,
                        input int exp_len, input string tag);
    int len;
    parity_mode = m;
    stop2       = s2;
    push(d);
    tx_valid = 1'b0;
    measure_busy(0, len);
    check(tag, len, exp_len);
    @(negedge CLK);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int len;
    int p;
    reset       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    parity_mode = 2'b00;
    stop2       = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_busy", uart_tx_busy, 1'b0);
      check("rst_ready", tx_ready, 1'b1);
      check("rst_level", fifo_level, 0);
    end
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Single 0xA5, no parity, one stop: latency and 100-cycle frame.
    push(8'hA5);
    tx_valid = 1'b0;
    check("lat_level", fifo_level, 1);
    check("lat_busy", uart_tx_busy, 1'b0);
    @(negedge CLK);
    check("pop_busy", uart_tx_busy, 1'b1);
    check("pop_txd", uart_txd, 1'b0);
    check("pop_level", fifo_level, 0);
    measure_busy(1, len);
    check("len_a5", len, 100);
    @(negedge CLK);
    check("sb_drained", sb.size(), 0);

    single(8'h07, 2'b01, 1'b0, 110, "len_even");
    single(8'h07, 2'b10, 1'b1, 120, "len_odd_s2");
    single(8'h00, 2'b01, 1'b0, 110, "len_even_zero");
    single(8'h5A, 2'b11, 1'b0, 100, "len_reserved");
    single(8'hC3, 2'b00, 1'b1, 110, "len_s2");

    // Burst of 17 with tx_valid held.
    parity_mode = 2'b00;
    stop2       = 1'b0;
    push(8'd1);
    p = cyc + 1;
    for (int k = 1; k < 17; k++) push(8'(k * 37 + 1));
    check("burst_full_level", fifo_level, 16);
    check("burst_ready_low", tx_ready, 1'b0);
    tx_data = 8'hEE;
    repeat (20) @(negedge CLK);
    check("full_hold_level", fifo_level, 16);
    tx_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      while (cyc < p + 100 * k + 5) @(negedge CLK);
      check("burst_level", fifo_level, 16 - k);
    end
    check("burst_ready_back", tx_ready, 1'b1);
    for (int t = 0; t < 3000 && uart_tx_busy; t++) @(negedge CLK);
    check("burst_end_cycle", cyc, p + 1700);
    check("burst_drained", sb.size(), 0);
    repeat (5) @(negedge CLK);

    // Push coinciding with the pop at the end of a stop bit, level 3.
    push(8'h11);
    p = cyc + 1;
    push(8'h22);
    push(8'h33);
    push(8'h44);
    tx_valid = 1'b0;
    check("sim_level_pre", fifo_level, 3);
    while (cyc < p + 99) @(negedge CLK);
    check("sim_stop_high", uart_txd, 1'b1);
    push(8'h55);
    tx_valid = 1'b0;
    check("sim_level_kept", fifo_level, 3);
    check("sim_next_start", uart_txd, 1'b0);
    check("sim_busy", uart_tx_busy, 1'b1);
    for (int t = 0; t < 3000 && uart_tx_busy; t++) @(negedge CLK);
    check("sim_drained", sb.size(), 0);
    repeat (5) @(negedge CLK);

    // Reset in the middle of the 0x3C data bits with four words queued.
    push(8'h3C);
    for (int k = 0; k < 4; k++) push(8'(8'h80 + k));
    tx_valid = 1'b0;
    check("mid_level", fifo_level, 4);
    repeat (20) @(negedge CLK);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_txd", uart_txd, 1'b1);
    check("mid_rst_busy", uart_tx_busy, 1'b0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    repeat (600) @(negedge CLK);
    check("post_rst_txd", uart_txd, 1'b1);
    check("post_rst_busy", uart_tx_busy, 1'b0);
    check("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
